alu_issue: RTL

Two-stage execute-issue pipeline that drives the `alu` control/operand interface (`m`, `a`, `b`) and collects its `y`/`cmp` results. Accepts decoded integer instructions on a valid/ready handshake and registers them in stage E, where they drive the external `alu` combinationally. Captures the `alu` result in stage W and presents it downstream on a second valid/ready handshake. Resolves conditional branches from `cmp` and computes branch targets.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_issue_map.sv | 44 ++++
 rtl/alu_issue.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the execute-issue block and its alu interface.
package alu_pkg;

  // alu op-select encodings
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // decoded instruction class
  typedef enum logic [1:0] {
    KIND_OP     = 2'd0,
    KIND_OP_IMM = 2'd1,
    KIND_BRANCH = 2'd2,
    KIND_AUIPC  = 2'd3
  } kind_e;

  // control bundle produced by the op mapper
  typedef struct packed {
    logic [3:0] m;        // alu op select
    logic       a_pc;     // operand a comes from pc instead of rs1
    logic       b_imm;    // operand b comes from imm instead of rs2
    logic       wen;      // register write enable (already cleared when illegal)
    logic       branch;   // conditional branch: resolve from cmp, compute target
    logic       illegal;  // unsupported encoding
  } map_t;

endpackage

// File: rtl/alu_issue_map.sv
// Combinational decode of kind/funct3/funct7b5 into alu control and operand selects.
module alu_issue_map
  import alu_pkg::*;
(
  input  kind_e      kind,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output map_t       map
);

  // Map the instruction class onto alu op, operand selects and flags.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a latch behind.
    map = '0;
    case (kind)
      KIND_OP: begin
        map.m       = {funct7b5, funct3};
        map.wen     = 1'b1;
        // Only ADD/SUB and SRL/SRA have a bit-30 variant.
        map.illegal = funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101);
      end
      KIND_OP_IMM: begin
        // Bit 30 of an immediate is data except for SRAI, so there is no SUBI.
        map.m     = {funct7b5 & (funct3 == 3'b101), funct3};
        map.b_imm = 1'b1;
        map.wen   = 1'b1;
      end
      KIND_BRANCH: begin
        map.m       = {1'b0, funct3};
        map.branch  = 1'b1;
        map.illegal = (funct3[2:1] == 2'b01);
      end
      KIND_AUIPC: begin
        map.m     = ALU_ADD;
        map.a_pc  = 1'b1;
        map.b_imm = 1'b1;
        map.wen   = 1'b1;
      end
      default: map = '0;
    endcase
    if (map.illegal) map.wen = 1'b0;
  end

endmodule

// File: rtl/alu_issue.sv
// Two-stage execute-issue pipeline: E drives the external alu, W holds the result
// for the downstream valid/ready handshake.
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_kind,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  output logic [3:0]      alu_m,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_y,
  input  logic            alu_cmp,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_result,
  output logic            out_wen,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  // E-stage registers
  logic            e_valid;
  kind_e           e_kind;
  logic [2:0]      e_funct3;
  logic            e_funct7b5;
  logic [XLEN-1:0] e_rs1, e_rs2, e_imm, e_pc;
  logic [4:0]      e_rd;

  // W-stage registers
  logic            w_valid;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_result;
  logic            w_wen;
  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic            w_illegal;

  // handshake
  logic w_adv, e_adv, in_fire;

  assign w_adv    = !w_valid || out_ready;
  assign e_adv    = !e_valid || w_adv;
  assign in_ready = e_adv && !flush && !rst;
  assign in_fire  = in_valid && in_ready;

  // decode of the instruction sitting in E
  map_t e_map;

  alu_issue_map u_map (
    .kind     (e_kind),
    .funct3   (e_funct3),
    .funct7b5 (e_funct7b5),
    .map      (e_map)
  );

  assign alu_m = e_map.m;
  assign alu_a = e_map.a_pc  ? e_pc  : e_rs1;
  assign alu_b = e_map.b_imm ? e_imm : e_rs2;

  // E-stage results headed for W
  logic [XLEN-1:0] e_result, e_target;
  logic            e_taken;

  assign e_result = e_map.illegal ? '0 :
                    e_map.branch  ? e_pc + XLEN'(4) : alu_y;
  assign e_taken  = e_map.branch && !e_map.illegal && alu_cmp;
  assign e_target = e_map.branch ? e_pc + e_imm : '0;

  // E stage: accept from the input handshake, hand over to W, or hold.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: data registers are reset too, because their reset value is visible on alu_* and out_*.
    if (rst) begin
      e_valid    <= 1'b0;
      e_kind     <= KIND_OP;
      e_funct3   <= '0;
      e_funct7b5 <= 1'b0;
      e_rs1      <= '0;
      e_rs2      <= '0;
      e_imm      <= '0;
      e_pc       <= '0;
      e_rd       <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      if (flush)        e_valid <= 1'b0;
      else if (in_fire) e_valid <= 1'b1;
      else if (w_adv)   e_valid <= 1'b0;
      if (in_fire) begin
        e_kind     <= kind_e'(in_kind);
        e_funct3   <= in_funct3;
        e_funct7b5 <= in_funct7b5;
        e_rs1      <= in_rs1;
        e_rs2      <= in_rs2;
        e_imm      <= in_imm;
        e_pc       <= in_pc;
        e_rd       <= in_rd;
      end
    end
  end

  // W stage: capture the alu result when E moves forward, hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid   <= 1'b0;
      w_rd      <= '0;
      w_result  <= '0;
      w_wen     <= 1'b0;
      w_taken   <= 1'b0;
      w_target  <= '0;
      w_illegal <= 1'b0;
    end else begin
      if (flush)      w_valid <= 1'b0;
      else if (w_adv) w_valid <= e_valid;
      if (e_valid && w_adv) begin
        w_rd      <= e_rd;
        w_result  <= e_result;
        w_wen     <= e_map.wen;
        w_taken   <= e_taken;
        w_target  <= e_target;
        w_illegal <= e_map.illegal;
      end
    end
  end

  assign out_valid   = w_valid;
  assign out_rd      = w_rd;
  assign out_result  = w_result;
  assign out_wen     = w_wen;
  assign out_taken   = w_taken;
  assign out_target  = w_target;
  assign out_illegal = w_illegal;

endmodule
